sm_event_arbiter: RTL and testbench
===================================

SM_EVENT_ARBITER -- requirements
Module: sm_event_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 2, meaning the number of debug event sources (2..8).
REQ-002 The block SHALL have parameter MAX_DI_PKT_LEN, default 12, meaning the maximum legal packet length in flits, header included.
REQ-003 The block SHALL have port clk  input  1  system clock; all logic is in this one clock domain.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid  input  NUM_SRC  per-source flit valid.
REQ-006 The block SHALL have port in_last  input  NUM_SRC  per-source last-flit marker.
REQ-007 The block SHALL have port in_data  input  16*NUM_SRC  per-source flit data; source i occupies bits [16i+15:16i].
REQ-008 The block SHALL have port in_ready  output  NUM_SRC  per-source ready.
REQ-009 The block SHALL have port out_valid  output  1  merged flit valid.
REQ-010 The block SHALL have port out_last  output  1  merged last marker.
REQ-011 The block SHALL have port out_data  output  16  merged flit data.
REQ-012 The block SHALL have port out_ready  input  1  downstream ready, from the regaccess layer module_in_ready.
REQ-013 The block SHALL have port grant  output  NUM_SRC  one-hot current owner; all zero when idle.
REQ-014 The block SHALL have port err_len  output  1  sticky flag: a packet exceeded MAX_DI_PKT_LEN.

Function
REQ-015 States SHALL be IDLE and BUSY, encoded as state plus an owner index register.
REQ-016 In IDLE, with any in_valid set, the arbiter SHALL choose the first requester at or after rr_ptr in round-robin order, load the owner, set grant, and enter BUSY on the next cycle; no flit is transferred in the IDLE cycle.
REQ-017 In BUSY, out_valid/out_last/out_data SHALL combinationally equal the owner's in_valid/in_last/in_data, in_ready[owner] SHALL equal out_ready, and in_ready of every other source SHALL be 0.
REQ-018 A transfer SHALL occur when out_valid and out_ready are both high; a flit count (width clog2(MAX_DI_PKT_LEN+1)) SHALL increment per transfer and clear on packet end.
REQ-019 A transfer with out_last=1 SHALL end the packet: return to IDLE next cycle, set rr_ptr to owner+1 modulo NUM_SRC, and clear grant.
REQ-020 Grant SHALL be packet-atomic: the owner SHALL NOT change mid-packet regardless of other requests or owner stalls (in_valid low).
REQ-021 If a transfer without out_last brings the flit count to MAX_DI_PKT_LEN, the block SHALL set err_len and terminate the packet as if last, so the next flit of that source starts a new arbitration.
REQ-022 When the arbiter forces termination, the out_last presented downstream on that flit SHALL be forced to 1 so downstream framing stays intact.
REQ-023 In IDLE, out_valid SHALL be 0 and all in_ready SHALL be 0.
REQ-024 Single requester: worst-case arbitration overhead SHALL be one idle cycle per packet; back-to-back packets from one source SHALL each take length+1 cycles at full out_ready.
REQ-025 err_len SHALL stay set until reset.

Reset
REQ-026 Asserting rst_n low SHALL immediately force state=IDLE, grant=0, out_valid=0, in_ready=0, rr_ptr=0, flit count=0, and err_len=0, including mid-packet; a packet in flight is abandoned without emitting last.
REQ-027 After rst_n deasserts, the first arbitration SHALL favour source 0 when multiple sources request.

Verification
REQ-028 Simultaneous 3-flit packets on src0 and src1, out_ready=1 -> src0 flits on cycles 2..4 with last on the 3rd; src1 granted next and its flits on cycles 6..8; grant sequence 01,00,10.
REQ-029 src1 mid-packet with in_valid low for 5 cycles while src0 requests -> grant holds 10 throughout; out_valid=0 during the gap; src0 is served only after src1's last.
REQ-030 out_ready toggling 1,0,1,0 during a 4-flit packet -> exactly 4 transfers; out_data sequence is unchanged and in order; in_ready[owner] mirrors out_ready.
REQ-031 With MAX_DI_PKT_LEN=12, src0 sends 14 flits with no last -> the 12th flit is emitted with out_last=1, err_len=1; flits 13..14 form a new packet after re-arbitration.
REQ-032 rst_n pulsed low during the 2nd flit of a packet -> same cycle grant=0, out_valid=0; after release, src0 and src1 both requesting -> src0 granted first.

Source files
------------

// File: rtl/sm_event_arbiter_if.sv
// Bus bundle for sm_event_arbiter: per-source flit inputs, merged flit output and status.
// The master side drives the sources and downstream ready; the slave side is the arbiter.
interface sm_event_arbiter_if #(
  parameter int NUM_SRC = 2
);
  logic [NUM_SRC-1:0]    in_valid;
  logic [NUM_SRC-1:0]    in_last;
  logic [16*NUM_SRC-1:0] in_data;
  logic [NUM_SRC-1:0]    in_ready;
  logic                  out_valid;
  logic                  out_last;
  logic [15:0]           out_data;
  logic                  out_ready;
  logic [NUM_SRC-1:0]    grant;
  logic                  err_len;

  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_last, out_data, grant, err_len
  );

  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_last, out_data, grant, err_len
  );
endinterface

// File: rtl/sm_event_arbiter.sv
// Packet-atomic round-robin merge of NUM_SRC debug event flit streams into one stream,
// with forced termination and a sticky error when a packet overruns MAX_DI_PKT_LEN.
module sm_event_arbiter #(
  parameter int NUM_SRC        = 2,
  parameter int MAX_DI_PKT_LEN = 12
) (
  input logic              clk,
  input logic              rst_n,
  sm_event_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = $clog2(MAX_DI_PKT_LEN + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rrPtr_q, rrPtr_d;
  logic [CNT_W-1:0]   flitCnt_q, flitCnt_d;
  logic               errLen_q, errLen_d;

  logic               pickFound;
  logic [IDX_W-1:0]   pickIdx;
  logic               ownValid;
  logic               ownLast;
  logic [15:0]        ownData;
  logic               atLimit;

  // Both operands are below NUM_SRC, so one conditional subtraction is a full modulo.
  function automatic logic [IDX_W-1:0] wrapAdd(input logic [IDX_W-1:0] a,
                                                input logic [IDX_W-1:0] b);
    logic [IDX_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= (IDX_W+1)'(NUM_SRC)) begin
      sum = sum - (IDX_W+1)'(NUM_SRC);
    end
    return sum[IDX_W-1:0];
  endfunction

  // Scanning from the far end lets the requester closest to rrPtr_q overwrite the others.
  always_comb begin
    pickFound = 1'b0;
    pickIdx   = rrPtr_q;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (bus.in_valid[wrapAdd(rrPtr_q, IDX_W'(i))]) begin
        pickFound = 1'b1;
        pickIdx   = wrapAdd(rrPtr_q, IDX_W'(i));
      end
    end
  end

  always_comb begin
    ownValid = 1'b0;
    ownLast  = 1'b0;
    ownData  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (owner_q == IDX_W'(i)) begin
        ownValid = bus.in_valid[i];
        ownLast  = bus.in_last[i];
        ownData  = bus.in_data[16*i +: 16];
      end
    end
  end

  // The flit that would bring the count to the limit is cut short and marked last.
  assign atLimit = (flitCnt_q == CNT_W'(MAX_DI_PKT_LEN - 1));

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rrPtr_d       = rrPtr_q;
    flitCnt_d     = flitCnt_q;
    errLen_d      = errLen_q;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_data  = '0;
    bus.in_ready  = '0;
    bus.grant     = '0;

    unique case (state_q)
      IDLE: begin
        if (pickFound) begin
          owner_d = pickIdx;
          state_d = BUSY;
        end
      end

      BUSY: begin
        bus.out_valid = ownValid;
        bus.out_last  = ownLast | atLimit;
        bus.out_data  = ownData;
        for (int i = 0; i < NUM_SRC; i++) begin
          bus.grant[i]    = (owner_q == IDX_W'(i));
          bus.in_ready[i] = (owner_q == IDX_W'(i)) & bus.out_ready;
        end
        if (ownValid && bus.out_ready) begin
          if (ownLast || atLimit) begin
            state_d   = IDLE;
            rrPtr_d   = wrapAdd(owner_q, IDX_W'(1));
            flitCnt_d = '0;
            if (!ownLast) begin
              errLen_d = 1'b1;
            end
          end else begin
            flitCnt_d = flitCnt_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.err_len = errLen_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rrPtr_q   <= '0;
      flitCnt_q <= '0;
      errLen_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rrPtr_q   <= rrPtr_d;
      flitCnt_q <= flitCnt_d;
      errLen_q  <= errLen_d;
    end
  end

  grantOneHot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.grant));
  readyOnlyOwner: assert property (@(posedge clk) disable iff (!rst_n)
                                   (bus.in_ready & ~bus.grant) == '0);

endmodule

// File: tb/tb_sm_event_arbiter.sv
// Self-checking bench for sm_event_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic compared against a packet-level reference model.
module tb_sm_event_arbiter;

  localparam int NSRC   = 2;
  localparam int MAXLEN = 12;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sm_event_arbiter_if #(.NUM_SRC(NSRC)) bus ();

  sm_event_arbiter #(
    .NUM_SRC       (NSRC),
    .MAX_DI_PKT_LEN(MAXLEN)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int nChecks = 0;
  int nPass   = 0;

  // Reference model: owner is -1 while no packet is granted.
  int   mOwner;
  int   mPtr;
  int   mCnt;
  bit   mErr;
  logic [1:0]  sIv, sIl;
  logic [15:0] sD0, sD1;
  logic        sOrdy;
  logic [1:0]  eGrant, eReady;
  logic        eValid, eLast, eErr;
  logic [15:0] eData;

  typedef struct {
    logic [1:0]  iv;
    logic [1:0]  il;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        ordy;
    logic [1:0]  grant;
    logic        ov;
    logic        ol;
    logic [15:0] od;
    logic [1:0]  ir;
  } vec_t;

  vec_t tbl[9];

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic modelReset();
    mOwner = -1;
    mPtr   = 0;
    mCnt   = 0;
    mErr   = 1'b0;
  endtask

  task automatic modelPredict();
    eGrant = '0;
    eReady = '0;
    eValid = 1'b0;
    eLast  = 1'b0;
    eData  = '0;
    eErr   = mErr;
    if (mOwner >= 0) begin
      eGrant[mOwner] = 1'b1;
      eReady[mOwner] = sOrdy;
      eValid         = sIv[mOwner];
      eLast          = sIl[mOwner] || (mCnt + 1 == MAXLEN);
      eData          = (mOwner == 0) ? sD0 : sD1;
    end
  endtask

  task automatic modelAdvance();
    bit found;
    int s;
    found = 1'b0;
    if (mOwner < 0) begin
      for (int k = 0; k < NSRC; k++) begin
        s = (mPtr + k) % NSRC;
        if (!found && sIv[s]) begin
          mOwner = s;
          found  = 1'b1;
        end
      end
    end else if (sIv[mOwner] && sOrdy) begin
      mCnt++;
      if (sIl[mOwner] || mCnt == MAXLEN) begin
        if (!sIl[mOwner]) mErr = 1'b1;
        mPtr   = (mOwner + 1) % NSRC;
        mOwner = -1;
        mCnt   = 0;
      end
    end
  endtask

  // Called at a falling edge; leaves outputs settled for checking.
  task automatic applyStimulus(input logic [1:0] iv, input logic [1:0] il,
                               input logic [15:0] d0, input logic [15:0] d1, input logic ordy);
    sIv = iv; sIl = il; sD0 = d0; sD1 = d1; sOrdy = ordy;
    bus.in_valid  = iv;
    bus.in_last   = il;
    bus.in_data   = {d1, d0};
    bus.out_ready = ordy;
    #1;
    modelPredict();
  endtask

  task automatic checkModel();
    checkOutput("grant", 16'(bus.grant), 16'(eGrant));
    checkOutput("in_ready", 16'(bus.in_ready), 16'(eReady));
    checkOutput("out_valid", 16'(bus.out_valid), 16'(eValid));
    checkOutput("err_len", 16'(bus.err_len), 16'(eErr));
    if (eValid) begin
      checkOutput("out_last", 16'(bus.out_last), 16'(eLast));
      checkOutput("out_data", bus.out_data, eData);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelAdvance();
    @(negedge clk);
  endtask

  task automatic resetDut();
    bus.in_valid  = '0;
    bus.in_last   = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int   sent;
  int   phase;
  bit   errChecked;
  logic ordyBit;
  int   rem[NSRC];
  int   seqn[NSRC];
  logic [1:0]  rIv, rIl;
  logic [15:0] rD[NSRC];

  initial begin
    tbl[0] = '{2'b11, 2'b00, 16'hA001, 16'hB001, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00};
    tbl[1] = '{2'b11, 2'b00, 16'hA001, 16'hB001, 1'b1, 2'b01, 1'b1, 1'b0, 16'hA001, 2'b01};
    tbl[2] = '{2'b11, 2'b00, 16'hA002, 16'hB001, 1'b1, 2'b01, 1'b1, 1'b0, 16'hA002, 2'b01};
    tbl[3] = '{2'b11, 2'b01, 16'hA003, 16'hB001, 1'b1, 2'b01, 1'b1, 1'b1, 16'hA003, 2'b01};
    tbl[4] = '{2'b10, 2'b00, 16'h0000, 16'hB001, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00};
    tbl[5] = '{2'b10, 2'b00, 16'h0000, 16'hB001, 1'b1, 2'b10, 1'b1, 1'b0, 16'hB001, 2'b10};
    tbl[6] = '{2'b10, 2'b00, 16'h0000, 16'hB002, 1'b1, 2'b10, 1'b1, 1'b0, 16'hB002, 2'b10};
    tbl[7] = '{2'b10, 2'b10, 16'h0000, 16'hB003, 1'b1, 2'b10, 1'b1, 1'b1, 16'hB003, 2'b10};
    tbl[8] = '{2'b00, 2'b00, 16'h0000, 16'h0000, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00};

    // Reset state, sampled while reset is held with sources requesting.
    rst_n = 1'b0;
    modelReset();
    bus.in_valid = 2'b11; bus.in_last = 2'b00; bus.in_data = '0; bus.out_ready = 1'b1;
    @(negedge clk); #1;
    checkOutput("rstGrant", 16'(bus.grant), 16'h0);
    checkOutput("rstValid", 16'(bus.out_valid), 16'h0);
    checkOutput("rstReady", 16'(bus.in_ready), 16'h0);
    checkOutput("rstErr", 16'(bus.err_len), 16'h0);

    // Two simultaneous 3-flit packets.
    resetDut();
    for (int r = 0; r < 9; r++) begin
      applyStimulus(tbl[r].iv, tbl[r].il, tbl[r].d0, tbl[r].d1, tbl[r].ordy);
      checkOutput($sformatf("tbl%0d.grant", r), 16'(bus.grant), 16'(tbl[r].grant));
      checkOutput($sformatf("tbl%0d.valid", r), 16'(bus.out_valid), 16'(tbl[r].ov));
      checkOutput($sformatf("tbl%0d.ready", r), 16'(bus.in_ready), 16'(tbl[r].ir));
      if (tbl[r].ov) begin
        checkOutput($sformatf("tbl%0d.last", r), 16'(bus.out_last), 16'(tbl[r].ol));
        checkOutput($sformatf("tbl%0d.data", r), bus.out_data, tbl[r].od);
      end
      tick();
    end

    // Owner stall: src1 goes quiet mid-packet while src0 keeps requesting.
    resetDut();
    applyStimulus(2'b10, 2'b00, 16'h0, 16'hB001, 1'b1); checkModel(); tick();
    applyStimulus(2'b10, 2'b00, 16'h0, 16'hB001, 1'b1); checkModel(); tick();
    for (int g = 0; g < 5; g++) begin
      applyStimulus(2'b01, 2'b00, 16'hA001, 16'h0, 1'b1); checkModel();
      checkOutput("gapGrant", 16'(bus.grant), 16'h2);
      checkOutput("gapValid", 16'(bus.out_valid), 16'h0);
      tick();
    end
    applyStimulus(2'b11, 2'b10, 16'hA001, 16'hB002, 1'b1); checkModel();
    checkOutput("stallLast", 16'(bus.out_last), 16'h1);
    tick();
    applyStimulus(2'b01, 2'b01, 16'hA001, 16'h0, 1'b1); checkModel();
    checkOutput("stallIdle", 16'(bus.grant), 16'h0);
    tick();
    applyStimulus(2'b01, 2'b01, 16'hA001, 16'h0, 1'b1); checkModel();
    checkOutput("stallNext", 16'(bus.grant), 16'h1);
    tick();

    // Downstream backpressure toggling during a 4-flit packet.
    resetDut();
    sent = 0; phase = 0;
    for (int c = 0; c < 20 && sent < 4; c++) begin
      ordyBit = (phase % 2 == 0);
      applyStimulus(2'b01, {1'b0, sent == 3}, 16'hC000 + 16'(sent), 16'h0, ordyBit);
      checkModel();
      if (bus.grant == 2'b01) begin
        checkOutput("readyMirror", 16'(bus.in_ready[0]), 16'(ordyBit));
        if (bus.out_valid && ordyBit) begin
          checkOutput("seqData", bus.out_data, 16'hC000 + 16'(sent));
          sent++;
        end
        phase++;
      end
      tick();
    end
    checkOutput("xferCount", 16'(sent), 16'd4);
    applyStimulus(2'b00, 2'b00, 16'h0, 16'h0, 1'b1); checkModel(); tick();

    // Overlong packet: 14 flits without last.
    resetDut();
    sent = 0; errChecked = 1'b0;
    for (int c = 0; c < 40 && sent < 14; c++) begin
      applyStimulus(2'b01, 2'b00, 16'hD001 + 16'(sent), 16'h0, 1'b1);
      checkModel();
      if (bus.grant == 2'b01 && bus.out_valid) begin
        sent++;
        checkOutput($sformatf("ovrLast%0d", sent), 16'(bus.out_last), 16'(sent == 12));
      end
      tick();
      if (sent == 12 && !errChecked) begin
        checkOutput("errSet", 16'(bus.err_len), 16'h1);
        checkOutput("reArbIdle", 16'(bus.grant), 16'h0);
        errChecked = 1'b1;
      end
    end
    checkOutput("ovrCount", 16'(sent), 16'd14);
    applyStimulus(2'b00, 2'b00, 16'h0, 16'h0, 1'b1); checkModel();
    checkOutput("errSticky", 16'(bus.err_len), 16'h1);
    tick();

    // Reset during the 2nd flit, with the pointer previously moved to src1.
    resetDut();
    applyStimulus(2'b01, 2'b00, 16'hE001, 16'h0, 1'b1); checkModel(); tick();
    applyStimulus(2'b01, 2'b00, 16'hE001, 16'h0, 1'b1); checkModel(); tick();
    applyStimulus(2'b01, 2'b01, 16'hE002, 16'h0, 1'b1); checkModel(); tick();
    applyStimulus(2'b01, 2'b00, 16'hE003, 16'h0, 1'b1); checkModel(); tick();
    applyStimulus(2'b01, 2'b00, 16'hE003, 16'h0, 1'b1); checkModel(); tick();
    applyStimulus(2'b01, 2'b00, 16'hE004, 16'h0, 1'b1); checkModel();
    checkOutput("preRstValid", 16'(bus.out_valid), 16'h1);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("midRstGrant", 16'(bus.grant), 16'h0);
    checkOutput("midRstValid", 16'(bus.out_valid), 16'h0);
    checkOutput("midRstReady", 16'(bus.in_ready), 16'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'b11, 2'b00, 16'hE005, 16'hF001, 1'b1); checkModel(); tick();
    applyStimulus(2'b11, 2'b00, 16'hE005, 16'hF001, 1'b1); checkModel();
    checkOutput("postRstFirst", 16'(bus.grant), 16'h1);
    tick();

    // Randomized traffic against the reference model.
    resetDut();
    for (int s = 0; s < NSRC; s++) begin
      rem[s]  = 0;
      seqn[s] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < NSRC; s++) begin
        if (rem[s] == 0 && $urandom_range(0, 3) == 0) rem[s] = int'($urandom_range(1, 15));
        rIv[s] = (rem[s] > 0) && ($urandom_range(0, 3) != 0);
        rIl[s] = (rem[s] == 1);
        rD[s]  = {4'(s), 12'(seqn[s])};
      end
      applyStimulus(rIv, rIl, rD[0], rD[1], $urandom_range(0, 3) != 0);
      checkModel();
      for (int s = 0; s < NSRC; s++) begin
        if (rIv[s] && eReady[s]) begin
          rem[s]--;
          seqn[s]++;
        end
      end
      tick();
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
